des_key_schedule: RTL

//  Iterative DES key-schedule generator feeding the round datapath (Expansion -> key XOR -> S_Boxes -> Permutation).

---
 rtl/des_key_if.sv | 24 ++
 rtl/des_key_schedule.sv | 134 +++++++++++++
 2 files changed

// File: rtl/des_key_if.sv
// Key-in / subkey-out handshake bundle for des_key_schedule.
// The master side supplies keys and consumes subkeys; the slave side is the key scheduler.
interface des_key_if;
    logic        key_valid;
    logic        key_ready;
    logic [63:0] key_i;
    logic        decrypt_i;
    logic        sk_valid;
    logic        sk_ready;
    logic [47:0] subkey_o;
    logic [3:0]  round_o;
    logic        last_o;
    logic        par_err_o;

    modport master (
        output key_valid, key_i, decrypt_i, sk_ready,
        input  key_ready, sk_valid, subkey_o, round_o, last_o, par_err_o
    );

    modport slave (
        input  key_valid, key_i, decrypt_i, sk_ready,
        output key_ready, sk_valid, subkey_o, round_o, last_o, par_err_o
    );
endinterface

// File: rtl/des_key_schedule.sv
// Iterative DES key schedule: one 48-bit round subkey per handshake, K1..K16 or K16..K1.
// Optional key-byte odd-parity flag when DES_KEY_PARITY_CHECK_EN is defined.
//
//   state | meaning
//   IDLE  | waiting for a key, key_ready high
//   GEN   | subkey_o valid, stepping C/D on each accepted subkey
module des_key_schedule #(
    parameter bit BACK_TO_BACK = 1'b1
) (
    input logic       clk,
    input logic       rst_n,
    des_key_if.slave  kif
);
    typedef enum logic {IDLE, GEN} state_t;

    // DES bit numbering: bit 1 is the MSB of the source vector
    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    // bit r set when round r+1 (0-based r) uses a 2-bit rotation
    localparam logic [15:0] SHIFT2 = 16'h7EFC;

    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] r;
        for (int i = 0; i < 56; i++) r[55-i] = k[64-PC1[i]];
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] r;
        for (int i = 0; i < 48; i++) r[47-i] = cd[56-PC2[i]];
        return r;
    endfunction

    function automatic logic [27:0] rotl(input logic [27:0] x, input logic two);
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rotr(input logic [27:0] x, input logic two);
        return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    state_t      state, state_nx;
    logic [27:0] c_q, d_q;
    logic        dec_q;
    logic [3:0]  round_q;
    logic [55:0] cd0;
    logic        sk_valid, key_ready, last, load, adv;

    assign cd0  = pc1(kif.key_i);
    assign load = kif.key_valid & key_ready;
    assign adv  = sk_valid & kif.sk_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (load) state_nx = GEN;
            GEN:     if (adv && last) state_nx = load ? GEN : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        sk_valid  = (state == GEN);
        last      = sk_valid & (dec_q ? (round_q == 4'd0) : (round_q == 4'd15));
        key_ready = (state == IDLE) | (BACK_TO_BACK & last & kif.sk_ready);
    end

    // Encrypt pre-rotates by the round-1 shift at load so K1 is ready one cycle later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q     <= '0;
            d_q     <= '0;
            dec_q   <= 1'b0;
            round_q <= '0;
        end else if (load) begin
            dec_q   <= kif.decrypt_i;
            c_q     <= kif.decrypt_i ? cd0[55:28] : rotl(cd0[55:28], 1'b0);
            d_q     <= kif.decrypt_i ? cd0[27:0]  : rotl(cd0[27:0], 1'b0);
            round_q <= kif.decrypt_i ? 4'd15 : 4'd0;
        end else if (adv && !last) begin
            if (dec_q) begin
                c_q     <= rotr(c_q, SHIFT2[round_q]);
                d_q     <= rotr(d_q, SHIFT2[round_q]);
                round_q <= round_q - 4'd1;
            end else begin
                c_q     <= rotl(c_q, SHIFT2[round_q + 4'd1]);
                d_q     <= rotl(d_q, SHIFT2[round_q + 4'd1]);
                round_q <= round_q + 4'd1;
            end
        end
    end

    assign kif.key_ready = key_ready;
    assign kif.sk_valid  = sk_valid;
    assign kif.subkey_o  = pc2({c_q, d_q});
    assign kif.round_o   = round_q;
    assign kif.last_o    = last;

`ifdef DES_KEY_PARITY_CHECK_EN
    logic par_bad, par_err_q;

    always_comb begin
        par_bad = 1'b0;
        for (int b = 0; b < 8; b++) par_bad = par_bad | ~(^kif.key_i[8*b +: 8]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    par_err_q <= 1'b0;
        else if (load) par_err_q <= par_bad;
    end

    assign kif.par_err_o = par_err_q;
`else
    logic unused_parity_bits;
    assign unused_parity_bits = ^{kif.key_i[56], kif.key_i[48], kif.key_i[40], kif.key_i[32],
                                  kif.key_i[24], kif.key_i[16], kif.key_i[8], kif.key_i[0]};
    assign kif.par_err_o = 1'b0;
`endif
endmodule
